// File: rtl/alu_exec_stage.sv
// Sequential execute stage around a combinational 32-bit ALU: R-type accept, register-file
// operand read, ALU drive, result capture and writeback, one instruction every four cycles.
module alu_exec_stage #(
  parameter int FUNCT_MIN = 27,
  parameter int FUNCT_MAX = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        ld_en,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [5:0]  alu_funct,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic        done,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_zero,
  output logic        out_carry,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int DATA_W = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam logic [5:0] FUNCT_LO = 6'(FUNCT_MIN);
  localparam logic [5:0] FUNCT_HI = 6'(FUNCT_MAX);

  function automatic logic is_legal(input logic [31:0] instr);
    return (instr[31:26] == 6'd0) && (instr[5:0] >= FUNCT_LO) && (instr[5:0] <= FUNCT_HI);
  endfunction

  logic [1:0]        state;
  logic [25:0]       instr_p0;
  logic [DATA_W-1:0] rf [32];
  logic              accept;
  logic [4:0]        rs_p0;
  logic [4:0]        rt_p0;
  logic [4:0]        rd_p0;
  logic [4:0]        shamt_p0;
  logic [5:0]        funct_p0;

  assign rs_p0    = instr_p0[25:21];
  assign rt_p0    = instr_p0[20:16];
  assign rd_p0    = instr_p0[15:11];
  assign shamt_p0 = instr_p0[10:6];
  assign funct_p0 = instr_p0[5:0];

  // A preload strobe in IDLE owns the cycle, so no instruction is taken alongside it.
  assign in_ready = rst_n && (state == IDLE) && !ld_en;
  assign accept   = in_valid && in_ready;
  assign done     = (state == WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      illegal <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_legal(in_instr)) state <= READ;
            else                    illegal <= 1'b1;
          end
        end
        READ:    state <= EXEC;
        EXEC:    state <= WB;
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Accept stage: latch the instruction fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instr_p0 <= '0;
    else if (accept) instr_p0 <= in_instr[25:0];
  end

  // Read stage: drive ALU operands; they hold their last value outside READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_src1  <= '0;
      alu_src2  <= '0;
      alu_funct <= '0;
      alu_shamt <= '0;
    end else if (state == READ) begin
      alu_src1  <= (rs_p0 == 5'd0) ? '0 : rf[rs_p0];
      alu_src2  <= (rt_p0 == 5'd0) ? '0 : rf[rt_p0];
      alu_funct <= funct_p0;
      alu_shamt <= shamt_p0;
    end
  end

  // Exec stage: capture ALU outputs; these persist until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
      out_rd     <= '0;
    end else if (state == EXEC) begin
      out_result <= alu_result;
      out_zero   <= alu_zero;
      out_carry  <= alu_carry;
      out_rd     <= rd_p0;
    end
  end

  // Writeback stage and preload share the register file; they never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if ((state == IDLE) && ld_en && (ld_addr != 5'd0)) begin
      rf[ld_addr] <= ld_data;
    end else if ((state == WB) && (out_rd != 5'd0)) begin
      rf[out_rd] <= out_result;
    end
  end

  assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: bench-side ALU, register-file model, directed and random R-type traffic.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] alu_src1, alu_src2;
  logic [5:0]  alu_funct;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero, alu_carry;
  logic        done;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_zero, out_carry, illegal;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  logic        stub_mode = 1'b0;
  logic [31:0] stub_result = '0;
  logic        stub_zero = 1'b0, stub_carry = 1'b0;
  logic [32:0] alu_ref;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [31:0] m [32];

  typedef struct {
    logic        timeout;
    int          nwait;
    logic [3:0]  ill, dn, rdy;
    logic [31:0] s1, s2, res, dbg;
    logic [5:0]  fn;
    logic [4:0]  sh, rd;
    logic        z, c;
  } obs_t;

  always #5 clk = ~clk;

  alu_exec_stage #(.FUNCT_MIN(27), .FUNCT_MAX(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_funct(alu_funct), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .done(done), .out_result(out_result), .out_rd(out_rd), .out_zero(out_zero),
    .out_carry(out_carry), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] fn, input logic [4:0] sh);
    case (fn)
      6'd27:   return {1'b0, a} + {1'b0, b};
      6'd28:   return {1'b0, a} - {1'b0, b};
      6'd29:   return {1'b0, b << sh};
      6'd30:   return {1'b0, a & b};
      6'd31:   return {1'b0, a | b};
      6'd32:   return {1'b0, a ^ b};
      default: return 33'd0;
    endcase
  endfunction

  always_comb begin
    alu_ref    = ref_alu(alu_src1, alu_src2, alu_funct, alu_shamt);
    alu_result = alu_ref[31:0];
    alu_carry  = alu_ref[32];
    alu_zero   = (alu_ref[31:0] == 32'd0);
    if (stub_mode) begin
      alu_result = stub_result;
      alu_zero   = stub_zero;
      alu_carry  = stub_carry;
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  function automatic bit legal_ref(input logic [31:0] i);
    return (i[31:26] == 6'd0) && (i[5:0] >= 6'd27) && (i[5:0] <= 6'd32);
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m[a];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    step();
    ld_en = 1'b0;
    if (a != 5'd0) m[a] = d;
  endtask

  // Presents one instruction and records what the DUT shows in the four cycles after acceptance.
  task automatic issue(input logic [31:0] instr, output obs_t o);
    o.timeout = 1'b0; o.nwait = 0;
    in_instr = instr; in_valid = 1'b1; dbg_addr = instr[15:11];
    #1;
    while (!in_ready && o.nwait < 20) begin step(); o.nwait++; end
    if (!in_ready) o.timeout = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      o.ill[k] = illegal; o.dn[k] = done; o.rdy[k] = in_ready;
      if (k == 1) begin o.s1 = alu_src1; o.s2 = alu_src2; o.fn = alu_funct; o.sh = alu_shamt; end
      if (k == 2) begin o.res = out_result; o.rd = out_rd; o.z = out_zero; o.c = out_carry; end
      if (k == 3) o.dbg = dbg_data;
    end
  endtask

  localparam logic [12:0] HS_LEGAL   = {1'b0, 4'b0000, 4'b0100, 4'b1000};
  localparam logic [12:0] HS_ILLEGAL = {1'b0, 4'b0001, 4'b0000, 4'b1111};

  task automatic test_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    #3 rst_n = 1'b0;
    #2;
    vectors++; if ({in_ready, done, illegal, out_zero, out_carry} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctl got=%b exp=00000", {in_ready, done, illegal, out_zero, out_carry}); end
    vectors++; if ({alu_src1, alu_src2, alu_funct, alu_shamt} !== 75'd0) begin
      miscompares++; $display("FAIL reset_alu_drive got=%h exp=0", {alu_src1, alu_src2, alu_funct, alu_shamt}); end
    vectors++; if ({out_result, out_rd} !== 37'd0) begin
      miscompares++; $display("FAIL reset_out got=%h exp=0", {out_result, out_rd}); end
    step(); step();
    rst_n = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid_exec();
    int cnt0, bad;
    load(5'd1, 32'd5); load(5'd2, 32'd6);
    in_instr = mk(6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'd27); in_valid = 1'b1;
    #1; step();
    in_valid = 1'b0;
    step();
    cnt0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({in_ready, done, out_result} !== 34'd0) begin
      miscompares++; $display("FAIL midexec_reset_state got=%h exp=0", {in_ready, done, out_result}); end
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a); #1;
      if (dbg_data !== 32'd0) bad++;
    end
    vectors++; if (bad !== 0) begin
      miscompares++; $display("FAIL midexec_rf_cleared got=%0d nonzero regs exp=0", bad); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    repeat (5) step();
    vectors++; if (done_cnt !== cnt0) begin
      miscompares++; $display("FAIL midexec_no_done got=%0d pulses exp=0", done_cnt - cnt0); end
    dbg_addr = 5'd4; #1;
    vectors++; if (dbg_data !== 32'd0) begin
      miscompares++; $display("FAIL midexec_no_wb got=%h exp=0", dbg_data); end
  endtask

  task automatic test_preload();
    ld_addr = 5'd1; ld_data = 32'd3; ld_en = 1'b1; #1;
    vectors++; if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL preload_ready_low got=%b exp=0", in_ready); end
    step(); ld_en = 1'b0; m[1] = 32'd3;
    load(5'd2, 32'd4);
    load(5'd0, 32'hdead_beef);
    dbg_addr = 5'd1; #1;
    vectors++; if (dbg_data !== 32'd3) begin
      miscompares++; $display("FAIL preload_r1 got=%h exp=%h", dbg_data, 32'd3); end
    dbg_addr = 5'd2; #1;
    vectors++; if (dbg_data !== 32'd4) begin
      miscompares++; $display("FAIL preload_r2 got=%h exp=%h", dbg_data, 32'd4); end
    dbg_addr = 5'd0; #1;
    vectors++; if (dbg_data !== 32'd0) begin
      miscompares++; $display("FAIL preload_r0 got=%h exp=0", dbg_data); end
  endtask

  task automatic test_basic_op();
    obs_t o;
    stub_mode = 1'b1; stub_result = 32'd7; stub_zero = 1'b0; stub_carry = 1'b0;
    issue(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd27), o);
    m[3] = 32'd7;
    vectors++; if ({o.timeout, o.ill, o.dn, o.rdy} !== HS_LEGAL) begin
      miscompares++; $display("FAIL basic_handshake got=%b exp=%b", {o.timeout, o.ill, o.dn, o.rdy}, HS_LEGAL); end
    vectors++; if ({o.s1, o.s2, o.fn} !== {32'd3, 32'd4, 6'd27}) begin
      miscompares++; $display("FAIL basic_operands got=%h/%h/%0d exp=3/4/27", o.s1, o.s2, o.fn); end
    vectors++; if ({o.res, o.rd, o.z, o.c} !== {32'd7, 5'd3, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL basic_result got=%h rd=%0d z=%b c=%b exp=7 rd=3 z=0 c=0", o.res, o.rd, o.z, o.c); end
    vectors++; if (o.dbg !== 32'd7) begin
      miscompares++; $display("FAIL basic_wb_r3 got=%h exp=7", o.dbg); end
  endtask

  task automatic test_flags_rd0();
    obs_t o;
    stub_mode = 1'b1; stub_result = 32'd0; stub_zero = 1'b1; stub_carry = 1'b1;
    issue(mk(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'd28), o);
    vectors++; if ({o.timeout, o.ill, o.dn, o.rdy} !== HS_LEGAL) begin
      miscompares++; $display("FAIL flags_handshake got=%b exp=%b", {o.timeout, o.ill, o.dn, o.rdy}, HS_LEGAL); end
    vectors++; if ({o.res, o.rd, o.z, o.c} !== {32'd0, 5'd0, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL flags_result got=%h rd=%0d z=%b c=%b exp=0 rd=0 z=1 c=1", o.res, o.rd, o.z, o.c); end
    vectors++; if (o.dbg !== 32'd0) begin
      miscompares++; $display("FAIL flags_r0 got=%h exp=0", o.dbg); end
    stub_result = 32'd55; stub_zero = 1'b0; stub_carry = 1'b0;
    step(); step();
    vectors++; if ({out_result, out_zero, out_carry} !== {32'd0, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL flags_persist got=%h z=%b c=%b exp=0 z=1 c=1", out_result, out_zero, out_carry); end
  endtask

  task automatic test_shift();
    obs_t o;
    stub_mode = 1'b0;
    issue(mk(6'd0, 5'd1, 5'd2, 5'd6, 5'd2, 6'd29), o);
    m[6] = 32'd16;
    vectors++; if ({o.fn, o.sh} !== {6'd29, 5'd2}) begin
      miscompares++; $display("FAIL shift_fields got=%0d/%0d exp=29/2", o.fn, o.sh); end
    vectors++; if ({o.res, o.dbg} !== {32'd16, 32'd16}) begin
      miscompares++; $display("FAIL shift_result got=%h/%h exp=16/16", o.res, o.dbg); end
    issue(mk(6'd0, 5'd6, 5'd1, 5'd7, 5'd1, 6'd29), o);
    m[7] = 32'd6;
    vectors++; if ({o.timeout, o.ill, o.dn, o.rdy} !== HS_LEGAL || o.nwait !== 0) begin
      miscompares++; $display("FAIL shift_b2b got=%b wait=%0d exp=%b wait=0", {o.timeout, o.ill, o.dn, o.rdy}, o.nwait, HS_LEGAL); end
    vectors++; if ({o.s1, o.s2, o.sh, o.res} !== {32'd16, 32'd3, 5'd1, 32'd6}) begin
      miscompares++; $display("FAIL shift_second got=%h/%h/%0d/%h exp=10/3/1/6", o.s1, o.s2, o.sh, o.res); end
  endtask

  task automatic test_illegal();
    obs_t o;
    logic [31:0] bad_instr [3];
    int cnt0;
    stub_mode = 1'b0;
    bad_instr[0] = mk(6'd0, 5'd1, 5'd2, 5'd1, 5'd0, 6'd26);
    bad_instr[1] = mk(6'd0, 5'd1, 5'd2, 5'd1, 5'd0, 6'd33);
    bad_instr[2] = mk(6'd1, 5'd1, 5'd2, 5'd1, 5'd0, 6'd27);
    cnt0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      issue(bad_instr[i], o);
      vectors++; if ({o.timeout, o.ill, o.dn, o.rdy} !== HS_ILLEGAL) begin
        miscompares++; $display("FAIL illegal_%0d_handshake got=%b exp=%b", i, {o.timeout, o.ill, o.dn, o.rdy}, HS_ILLEGAL); end
      vectors++; if (o.dbg !== mread(5'd1)) begin
        miscompares++; $display("FAIL illegal_%0d_rf got=%h exp=%h", i, o.dbg, mread(5'd1)); end
    end
    vectors++; if (done_cnt !== cnt0) begin
      miscompares++; $display("FAIL illegal_no_done got=%0d pulses exp=0", done_cnt - cnt0); end
    issue(mk(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'd32), o);
    m[9] = 32'd7;
    vectors++; if ({o.timeout, o.ill, o.dn, o.rdy} !== HS_LEGAL || o.res !== 32'd7) begin
      miscompares++; $display("FAIL funct32_legal got=%b res=%h exp=%b res=7", {o.timeout, o.ill, o.dn, o.rdy}, o.res, HS_LEGAL); end
  endtask

  task automatic test_simultaneous();
    obs_t o;
    logic [31:0] instr;
    stub_mode = 1'b0;
    instr = mk(6'd0, 5'd5, 5'd1, 5'd8, 5'd0, 6'd27);
    ld_addr = 5'd5; ld_data = 32'd9; ld_en = 1'b1;
    in_instr = instr; in_valid = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL simul_ready got=%b exp=0", in_ready); end
    step();
    ld_en = 1'b0; m[5] = 32'd9;
    issue(instr, o);
    m[8] = 32'd12;
    vectors++; if (o.nwait !== 0 || {o.timeout, o.ill, o.dn, o.rdy} !== HS_LEGAL) begin
      miscompares++; $display("FAIL simul_accept got=%b wait=%0d exp=%b wait=0", {o.timeout, o.ill, o.dn, o.rdy}, o.nwait, HS_LEGAL); end
    vectors++; if ({o.s1, o.res, o.dbg} !== {32'd9, 32'd12, 32'd12}) begin
      miscompares++; $display("FAIL simul_values got=%h/%h/%h exp=9/c/c", o.s1, o.res, o.dbg); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] instr, a, b;
    logic [32:0] r;
    logic [5:0] op, fn;
    int sel;
    stub_mode = 1'b0;
    for (int i = 1; i < 32; i++) load(5'(i), $urandom);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) load(5'($urandom_range(0, 31)), $urandom);
      sel = int'($urandom_range(0, 3));
      op = 6'd0;
      fn = 6'($urandom_range(27, 32));
      if (sel == 0) begin op = 6'($urandom_range(1, 63)); fn = 6'($urandom_range(0, 63)); end
      else if (sel == 1) fn = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 26)) : 6'($urandom_range(33, 63));
      instr = mk(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), fn);
      a = mread(instr[25:21]);
      b = mread(instr[20:16]);
      r = ref_alu(a, b, instr[5:0], instr[10:6]);
      issue(instr, o);
      if (legal_ref(instr)) begin
        if (instr[15:11] != 5'd0) m[instr[15:11]] = r[31:0];
        vectors++; if ({o.timeout, o.ill, o.dn, o.rdy} !== HS_LEGAL) begin
          miscompares++; $display("FAIL rand%0d_handshake got=%b exp=%b instr=%h", n, {o.timeout, o.ill, o.dn, o.rdy}, HS_LEGAL, instr); end
        vectors++; if ({o.s1, o.s2, o.fn, o.sh} !== {a, b, instr[5:0], instr[10:6]}) begin
          miscompares++; $display("FAIL rand%0d_operands got=%h/%h/%0d/%0d exp=%h/%h/%0d/%0d", n, o.s1, o.s2, o.fn, o.sh, a, b, instr[5:0], instr[10:6]); end
        vectors++; if ({o.res, o.rd, o.z, o.c} !== {r[31:0], instr[15:11], r[31:0] == 32'd0, r[32]}) begin
          miscompares++; $display("FAIL rand%0d_result got=%h rd=%0d z=%b c=%b exp=%h rd=%0d c=%b", n, o.res, o.rd, o.z, o.c, r[31:0], instr[15:11], r[32]); end
      end else begin
        vectors++; if ({o.timeout, o.ill, o.dn, o.rdy} !== HS_ILLEGAL) begin
          miscompares++; $display("FAIL rand%0d_illegal got=%b exp=%b instr=%h", n, {o.timeout, o.ill, o.dn, o.rdy}, HS_ILLEGAL, instr); end
      end
      vectors++; if (o.dbg !== mread(instr[15:11])) begin
        miscompares++; $display("FAIL rand%0d_rf got=%h exp=%h", n, o.dbg, mread(instr[15:11])); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_exec();
    test_preload();
    test_basic_op();
    test_flags_rd0();
    test_shift();
    test_illegal();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
